// File: rtl/ram8_clr_pkg.sv
// ram8_clr_pkg: shared widths, depth and FSM state encoding for the
// 8x16 register file with sweep clear.
package ram8_clr_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram8_clr_if.sv
// ram8_clr_if: access bus for ram8_clr.
//   in, address, load, clr_req : requester -> memory
//   out, busy, clr_done        : memory -> requester
// master is the requester side, slave is the memory side.
interface ram8_clr_if;
  import ram8_clr_pkg::*;

  word_t in;
  addr_t address;
  logic  load;
  logic  clr_req;
  word_t out;
  logic  busy;
  logic  clr_done;

  modport master (
    output in, address, load, clr_req,
    input  out, busy, clr_done
  );

  modport slave (
    input  in, address, load, clr_req,
    output out, busy, clr_done
  );

endinterface

// File: rtl/ram8_clr_reg16.sv
// reg16: one storage word with synchronous clear and load enable.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (wins over load)
//   load, d    : write enable and write data
//   q          : stored word
module reg16
  import ram8_clr_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  load,
  input  word_t d,
  output word_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ram8_clr.sv
// ram8_clr: 8 x 16-bit register file with a one-word-per-cycle sweep clear.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.in / bus.address / bus.load : write port (IDLE only)
//   bus.clr_req                     : start sweep; beats a same-cycle load
//   bus.out                         : word[address] in IDLE, zero while busy
//   bus.busy                        : registered, high for the 8 sweep cycles
//   bus.clr_done                    : one-cycle pulse in the first IDLE cycle after a sweep
module ram8_clr
  import ram8_clr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ram8_clr_if.slave  bus
);

  state_e            state;
  state_e            state_nxt;
  addr_t             ptr;
  addr_t             ptr_nxt;
  logic [DEPTH-1:0]  wr_en;
  logic [DEPTH-1:0]  wr_clr;
  logic              done_nxt;
  logic              busy_q;
  logic              done_q;
  word_t             q [DEPTH];

  // Next state, sweep pointer and one-hot write/clear decode.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wr_en     = '0;
    wr_clr    = '0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end else if (bus.load) begin
          wr_en = DEPTH'(1) << bus.address;
        end
      end
      ST_CLEAR: begin
        wr_clr  = DEPTH'(1) << ptr;
        ptr_nxt = ptr + ADDR_W'(1);
        // Last word cleared on this edge: leave CLEAR and flag completion.
        if (ptr == ADDR_W'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pointer and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      busy_q <= (state_nxt == ST_CLEAR);
      done_q <= done_nxt;
    end
  end

  // Storage words.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg16 u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (wr_clr[i]),
      .load  (wr_en[i]),
      .d     (bus.in),
      .q     (q[i])
    );
  end

  // Read mux is blanked for the whole sweep.
  assign bus.out      = (state == ST_IDLE) ? q[bus.address] : '0;
  assign bus.busy     = busy_q;
  assign bus.clr_done = done_q;

endmodule

// File: tb/tb_ram8_clr.sv
// tb_ram8_clr: directed stimulus with a scoreboard queue; a monitor on the
// falling edge pops one expectation per cycle and compares it.
module tb_ram8_clr;
  import ram8_clr_pkg::*;

  typedef struct {
    word_t out;
    logic  busy;
    logic  done;
    string tag;
  } exp_t;

  logic clk;
  logic rst_n;
  ram8_clr_if bus ();

  exp_t sb [$];
  int   checks;
  int   errors;

  ram8_clr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge and queue what the
  // outputs must show during that cycle.
  task automatic step(input logic rst_v, input logic ld, input logic clr,
                      input addr_t a, input word_t d,
                      input word_t eo, input logic eb, input logic ed,
                      input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rst_v;
    bus.load    = ld;
    bus.clr_req = clr;
    bus.address = a;
    bus.in      = d;
    e.out  = eo;
    e.busy = eb;
    e.done = ed;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.out !== e.out || bus.busy !== e.busy || bus.clr_done !== e.done) begin
        errors++;
        $display("FAIL %s: got out=%h busy=%b done=%b, want out=%h busy=%b done=%b",
                 e.tag, bus.out, bus.busy, bus.clr_done, e.out, e.busy, e.done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.load    = 1'b0;
    bus.clr_req = 1'b0;
    bus.address = '0;
    bus.in      = '0;
    repeat (2) @(posedge clk);

    // Every word reads zero after reset.
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 3'(i), 16'h0, 16'h0000, 0, 0, "reset_read");

    // Single write to word 5, then read every address.
    step(1, 1, 0, 3'd5, 16'hBEEF, 16'h0000, 0, 0, "write5");
    step(1, 0, 0, 3'd5, 16'h0, 16'hBEEF, 0, 0, "read5");
    for (int i = 0; i < 8; i++)
      if (i != 5) step(1, 0, 0, 3'(i), 16'h0, 16'h0000, 0, 0, "read_other");

    // Fill with 0x1000+i and read back.
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 3'(i), 16'(16'h1000 + i), (i == 5) ? 16'hBEEF : 16'h0000, 0, 0, "fill");
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 3'(i), 16'h0, 16'(16'h1000 + i), 0, 0, "fill_read");

    // Sweep; a load to word 2 during busy must be dropped.
    step(1, 0, 1, 3'd0, 16'h0, 16'h1000, 0, 0, "clr_pulse");
    for (int k = 1; k <= 8; k++)
      step(1, (k == 3), 0, 3'(k - 1), 16'h1234, 16'h0000, 1, 0, "sweep");
    step(1, 0, 0, 3'd2, 16'h0, 16'h0000, 0, 1, "sweep_done");
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 3'(i), 16'h0, 16'h0000, 0, 0, "post_sweep");

    // clr_req beats a same-cycle load; load in the clr_done cycle writes.
    step(1, 1, 0, 3'd3, 16'h5555, 16'h0000, 0, 0, "pre3");
    step(1, 1, 1, 3'd3, 16'hAAAA, 16'h5555, 0, 0, "ld_and_clr");
    for (int k = 1; k <= 8; k++)
      step(1, 0, 0, 3'd3, 16'h0, 16'h0000, 1, 0, "sweep2");
    step(1, 1, 0, 3'd3, 16'h7777, 16'h0000, 0, 1, "done_load");
    step(1, 0, 0, 3'd3, 16'h0, 16'h7777, 0, 0, "done_load_read");

    // Reset in sweep cycle 4 after preloading 0xFFFF.
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 3'(i), 16'hFFFF, (i == 3) ? 16'h7777 : 16'h0000, 0, 0, "preload_ff");
    step(1, 0, 1, 3'd7, 16'h0, 16'hFFFF, 0, 0, "clr_ff");
    for (int k = 1; k <= 3; k++)
      step(1, 0, 0, 3'd7, 16'h0, 16'h0000, 1, 0, "sweep3");
    step(0, 0, 0, 3'd7, 16'h0, 16'h0000, 1, 0, "sweep3_rst");
    step(1, 1, 0, 3'd4, 16'h4444, 16'h0000, 0, 0, "after_rst_ld");
    step(1, 0, 0, 3'd4, 16'h0, 16'h4444, 0, 0, "after_rst_read4");
    for (int i = 0; i < 8; i++)
      if (i != 4) step(1, 0, 0, 3'(i), 16'h0, 16'h0000, 0, 0, "after_rst_read");

    // clr_req held for 20 cycles: back-to-back sweeps.
    for (int k = 0; k < 20; k++) begin
      if (k == 0)
        step(1, 0, 1, 3'd4, 16'h0, 16'h4444, 0, 0, "hold_start");
      else if (k % 9 == 0)
        step(1, 0, 1, 3'd4, 16'h0, 16'h0000, 0, 1, "hold_done");
      else
        step(1, 0, 1, 3'd4, 16'h0, 16'h0000, 1, 0, "hold_busy");
    end
    for (int k = 20; k < 27; k++)
      step(1, 0, 0, 3'd4, 16'h0, 16'h0000, 1, 0, "tail_busy");
    step(1, 0, 0, 3'd4, 16'h0, 16'h0000, 0, 1, "tail_done");
    step(1, 0, 0, 3'd4, 16'h0, 16'h0000, 0, 0, "tail_idle");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram8_clr.md
RAM8_CLR -- requirements
Module: ram8_clr

Interface
REQ-001 clk  input  1  rising-edge system clock; the only clock.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 in  input  16  write data.
REQ-004 address  input  3  word select for write and read.
REQ-005 load  input  1  write strobe; writes in to word[address] at next rising edge when accepted.
REQ-006 clr_req  input  1  request to sweep-clear all 8 words.
REQ-007 out  output  16  read data for word[address].
REQ-008 busy  output  1  high while clear sweep in progress.
REQ-009 clr_done  output  1  one-cycle pulse marking sweep completion.

Function
REQ-010 Storage SHALL be 8 words x 16 bits, indexed 0..7.
REQ-011 Write decode SHALL be one-hot: exactly word[address] loads when accepted, all other words hold.
REQ-012 load SHALL be accepted only in IDLE with clr_req low; accepted write is visible on out in the cycle after the edge (address unchanged).
REQ-013 out SHALL be combinational word[address] in IDLE; out SHALL be 16'h0000 while busy.
REQ-014 FSM states SHALL be IDLE and CLEAR only.
REQ-015 IDLE -> CLEAR when clr_req sampled high; ptr loads 0 on that edge.
REQ-016 In CLEAR, each rising edge SHALL zero word[ptr] and increment ptr (3-bit, 7 wraps to 0).
REQ-017 CLEAR -> IDLE on the edge that clears word 7; sweep is exactly 8 CLEAR cycles.
REQ-018 busy SHALL equal (state == CLEAR), registered, no combinational path from inputs.
REQ-019 clr_done SHALL be high for exactly the first IDLE cycle after CLEAR, low otherwise.
REQ-020 clr_req sampled with load in IDLE: clr_req wins, write dropped.
REQ-021 load and clr_req while busy SHALL be ignored (dropped, not queued).
REQ-022 clr_req held high continuously: a new sweep SHALL start in the clr_done cycle (IDLE -> CLEAR), clr_done still pulses.
REQ-023 Load accepted in the clr_done cycle SHALL write normally when clr_req is low.
REQ-024 address and in SHALL have no effect in CLEAR.

Reset
REQ-025 rst_n low at a rising edge SHALL force: state IDLE, ptr 0, all 8 words 16'h0000, busy 0, clr_done 0.
REQ-026 Reset SHALL override all inputs, including mid-sweep; first cycle after reset release is IDLE, load accepted.
REQ-027 out SHALL read 16'h0000 for every address after reset.

Structure
REQ-028 Shared package SHALL hold: word width (16), depth (8), address width (3), FSM state encoding constants (IDLE, CLEAR).
REQ-029 One sub-module SHALL exist: reg16, a 16-bit register with load and synchronous clear, instantiated 8 times.
REQ-030 FSM, ptr counter, one-hot decode and read mux SHALL live in ram8_clr; target size 120-400 lines.

Verification
REQ-031 Reset, then load=1, in=16'hBEEF, address=5 for one cycle -> next cycle address=5 gives out=16'hBEEF; addresses 0-4,6,7 give 16'h0000.
REQ-032 Fill all words with 16'h1000+i, pulse clr_req -> busy high for exactly 8 cycles, out=0 during busy, clr_done high in cycle 9, then all words read 16'h0000.
REQ-033 During busy, load=1, address=2, in=16'h1234 -> dropped; word 2 reads 16'h0000 after sweep.
REQ-034 Same-cycle load (address=3, in=16'hAAAA) and clr_req in IDLE -> sweep starts, word 3 reads 16'h0000 afterwards.
REQ-035 rst_n low at sweep cycle 4 after words preloaded with 16'hFFFF -> next cycle busy=0, clr_done=0, all 8 words 16'h0000.
REQ-036 clr_req held high 20 cycles -> back-to-back sweeps, clr_done pulses at cycles 9 and 18 after first sample, busy low only in those cycles.
